// File: rtl/alu_input_ctrl.sv
// Front-end controller for the 8-bit ALU. Conditions the Enter and Sign buttons,
// captures operands A and B from the switches, and steps through the ALU functions.
module alu_input_ctrl #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enter_btn,
  input  logic             sign_btn,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [3:0]       FN,
  output logic             signed_mode,
  output logic [2:0]       state_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [2:0] {
    StLoadA  = 3'd0,
    StLoadB  = 3'd1,
    StOpAdd  = 3'd2,
    StOpSub  = 3'd3,
    StOpMod3 = 3'd4
  } state_e;

  // Index 0 = Enter, index 1 = Sign.
  logic [1:0]             btn_raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [CntW-1:0]        cnt_q  [2];
  logic [1:0]             btn_sync;
  logic [1:0]             level_q;
  logic [1:0]             level_dly_q;
  logic [1:0]             btn_ev;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       fn_q, fn_d;
  logic             signed_q, signed_d;

  assign btn_raw = {sign_btn, enter_btn};

  // Synchronizer outputs and press events (one cycle after the debounced level rises).
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      btn_sync[i] = sync_q[i][SYNC_STAGES-1];
    end
    btn_ev = level_q & ~level_dly_q;
  end

  // Per-button synchronizer and debounce: level flips only after DEBOUNCE_CYC stable cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      level_q     <= '0;
      level_dly_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
        if (btn_sync[i] != level_q[i]) begin
          if (cnt_q[i] == CntW'(DEBOUNCE_CYC - 1)) begin
            level_q[i] <= ~level_q[i];
            cnt_q[i]   <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
      level_dly_q <= level_q;
    end
  end

  // Next state, operand capture and function code derived from the next state.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q ^ btn_ev[1];
    fn_d     = 4'b0000;

    case (state_q)
      StLoadA: begin
        a_d = sw;
        if (btn_ev[0]) state_d = StLoadB;
      end
      StLoadB: begin
        b_d = sw;
        if (btn_ev[0]) state_d = StOpAdd;
      end
      StOpAdd:  if (btn_ev[0]) state_d = StOpSub;
      StOpSub:  if (btn_ev[0]) state_d = StOpMod3;
      StOpMod3: if (btn_ev[0]) state_d = StLoadA;
      default:  state_d = StLoadA;
    endcase

    // FN[3] carries the sign mode only for arithmetic states.
    case (state_d)
      StLoadA:  fn_d = 4'b0000;
      StLoadB:  fn_d = 4'b0001;
      StOpAdd:  fn_d = {signed_d, 3'b010};
      StOpSub:  fn_d = {signed_d, 3'b011};
      StOpMod3: fn_d = {signed_d, 3'b100};
      default:  fn_d = 4'b0000;
    endcase
  end

  // Controller state and registered ALU inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StLoadA;
      a_q      <= '0;
      b_q      <= '0;
      fn_q     <= 4'b0000;
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fn_q     <= fn_d;
      signed_q <= signed_d;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign FN          = fn_q;
  assign signed_mode = signed_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Directed self-checking bench for alu_input_ctrl.
module tb_alu_input_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             reset_n;
  logic             enter_btn;
  logic             sign_btn;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       FN;
  logic             signed_mode;
  logic [2:0]       state_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  alu_input_ctrl #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2),
    .DEBOUNCE_CYC(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enter_btn  (enter_btn),
    .sign_btn   (sign_btn),
    .sw         (sw),
    .A          (A),
    .B          (B),
    .FN         (FN),
    .signed_mode(signed_mode),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press and release; both well beyond the worst-case latency.
  task automatic press_enter();
    enter_btn = 1'b1;
    cycles(12);
    enter_btn = 1'b0;
    cycles(12);
  endtask

  task automatic press_sign();
    sign_btn = 1'b1;
    cycles(12);
    sign_btn = 1'b0;
    cycles(12);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    chk_cnt++;
    if ({A, B, FN, signed_mode, state_o} !== {8'h00, 8'h00, 4'b0000, 1'b0, 3'd0})
      $display("FAIL reset_init: A=%h B=%h FN=%b sm=%b st=%0d, want 00 00 0000 0 0",
               A, B, FN, signed_mode, state_o);
    else pass_cnt++;
    cycles(3);
    reset_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_capture();
    sw = 8'h2C;
    cycles(2);
    chk_cnt++;
    if (A !== 8'h2C) $display("FAIL capture_live_a: A=%h want 2c", A);
    else pass_cnt++;
    press_enter();
    chk_cnt++;
    if ({state_o, FN, A} !== {3'd1, 4'b0001, 8'h2C})
      $display("FAIL capture_a: st=%0d FN=%b A=%h want 1 0001 2c", state_o, FN, A);
    else pass_cnt++;
    sw = 8'h81;
    press_enter();
    chk_cnt++;
    if ({state_o, FN, A, B} !== {3'd2, 4'b0010, 8'h2C, 8'h81})
      $display("FAIL capture_b: st=%0d FN=%b A=%h B=%h want 2 0010 2c 81", state_o, FN, A, B);
    else pass_cnt++;
    sw = 8'h55;
    cycles(4);
    chk_cnt++;
    if ({A, B} !== {8'h2C, 8'h81})
      $display("FAIL capture_hold: A=%h B=%h want 2c 81", A, B);
    else pass_cnt++;
  endtask

  task automatic test_cycle();
    press_enter();
    chk_cnt++;
    if ({state_o, FN} !== {3'd3, 4'b0011})
      $display("FAIL cycle_sub: st=%0d FN=%b want 3 0011", state_o, FN);
    else pass_cnt++;
    press_enter();
    chk_cnt++;
    if ({state_o, FN} !== {3'd4, 4'b0100})
      $display("FAIL cycle_mod3: st=%0d FN=%b want 4 0100", state_o, FN);
    else pass_cnt++;
    press_enter();
    chk_cnt++;
    if ({state_o, FN} !== {3'd0, 4'b0000})
      $display("FAIL cycle_wrap: st=%0d FN=%b want 0 0000", state_o, FN);
    else pass_cnt++;
    sw = 8'h3A;
    cycles(2);
    chk_cnt++;
    if ({A, B} !== {8'h3A, 8'h81})
      $display("FAIL cycle_live_a: A=%h B=%h want 3a 81", A, B);
    else pass_cnt++;
  endtask

  task automatic test_sign();
    press_enter();
    press_enter();
    press_enter();
    chk_cnt++;
    if ({state_o, FN, B} !== {3'd3, 4'b0011, 8'h3A})
      $display("FAIL sign_setup: st=%0d FN=%b B=%h want 3 0011 3a", state_o, FN, B);
    else pass_cnt++;
    press_sign();
    chk_cnt++;
    if ({state_o, FN, signed_mode} !== {3'd3, 4'b1011, 1'b1})
      $display("FAIL sign_toggle: st=%0d FN=%b sm=%b want 3 1011 1", state_o, FN, signed_mode);
    else pass_cnt++;
    press_enter();
    chk_cnt++;
    if (FN !== 4'b1100) $display("FAIL sign_mod3: FN=%b want 1100", FN);
    else pass_cnt++;
    press_enter();
    chk_cnt++;
    if ({state_o, FN, signed_mode} !== {3'd0, 4'b0000, 1'b1})
      $display("FAIL sign_load_a: st=%0d FN=%b sm=%b want 0 0000 1", state_o, FN, signed_mode);
    else pass_cnt++;
  endtask

  task automatic test_debounce();
    bit seen;
    // 3-cycle glitch must be rejected.
    enter_btn = 1'b1;
    cycles(3);
    enter_btn = 1'b0;
    cycles(15);
    chk_cnt++;
    if (state_o !== 3'd0) $display("FAIL deb_glitch: st=%0d want 0", state_o);
    else pass_cnt++;
    // Long hold: must advance within the latency bound, then exactly once.
    enter_btn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      if (state_o != 3'd0) begin
        seen = 1'b1;
        break;
      end
    end
    chk_cnt++;
    if (!seen) $display("FAIL deb_latency: st=%0d still 0 after 8 cycles, want 1", state_o);
    else pass_cnt++;
    cycles(42);
    enter_btn = 1'b0;
    cycles(15);
    chk_cnt++;
    if (state_o !== 3'd1) $display("FAIL deb_hold: st=%0d want 1", state_o);
    else pass_cnt++;
    // Bounce 1-0-1 then steady high.
    enter_btn = 1'b1;
    cycles(1);
    enter_btn = 1'b0;
    cycles(1);
    enter_btn = 1'b1;
    cycles(20);
    enter_btn = 1'b0;
    cycles(15);
    chk_cnt++;
    if (state_o !== 3'd2) $display("FAIL deb_bounce: st=%0d want 2", state_o);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    bit done;
    press_sign();
    chk_cnt++;
    if ({state_o, FN, signed_mode} !== {3'd2, 4'b0010, 1'b0})
      $display("FAIL sim_setup: st=%0d FN=%b sm=%b want 2 0010 0", state_o, FN, signed_mode);
    else pass_cnt++;
    enter_btn = 1'b1;
    sign_btn  = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (state_o != 3'd2) begin
        done = 1'b1;
        break;
      end
    end
    chk_cnt++;
    if (!done || {state_o, FN, signed_mode} !== {3'd3, 4'b1011, 1'b1})
      $display("FAIL sim_edge: st=%0d FN=%b sm=%b want 3 1011 1", state_o, FN, signed_mode);
    else pass_cnt++;
    cycles(10);
    enter_btn = 1'b0;
    sign_btn  = 1'b0;
    cycles(12);
  endtask

  task automatic test_reset_mid();
    chk_cnt++;
    if ({state_o, signed_mode} !== {3'd3, 1'b1})
      $display("FAIL rst_setup: st=%0d sm=%b want 3 1", state_o, signed_mode);
    else pass_cnt++;
    sign_btn = 1'b1;
    cycles(4);
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++;
    if ({A, B, FN, signed_mode, state_o} !== {8'h00, 8'h00, 4'b0000, 1'b0, 3'd0})
      $display("FAIL rst_async: A=%h B=%h FN=%b sm=%b st=%0d, want 00 00 0000 0 0",
               A, B, FN, signed_mode, state_o);
    else pass_cnt++;
    cycles(3);
    sign_btn = 1'b0;
    cycles(1);
    reset_n = 1'b1;
    cycles(15);
    chk_cnt++;
    if ({state_o, signed_mode, FN} !== {3'd0, 1'b0, 4'b0000})
      $display("FAIL rst_no_pending: st=%0d sm=%b FN=%b want 0 0 0000", state_o, signed_mode, FN);
    else pass_cnt++;
  endtask

  initial begin
    enter_btn = 1'b0;
    sign_btn  = 1'b0;
    sw        = '0;
    reset_n   = 1'b1;
    test_reset();
    test_capture();
    test_cycle();
    test_sign();
    test_debounce();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
